clock_route_path_ctrl: RTL and testbench

CLOCK_ROUTE_PATH_CTRL -- requirements
Module: clock_route_path_ctrl

---
 rtl/clock_route_pkg.sv | 25 ++
 rtl/clock_sync_2ff.sv | 31 +++
 rtl/clock_route_path_ctrl.sv | 177 +++++++++++++++++
 tb/tb_clock_route_path_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_route_pkg.sv
// Shared definitions for the clock route reconfiguration controller.
// Holds the sequencing state encoding, the default timing constants and a
// small helper used to size the phase counter.
package clock_route_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } route_state_e;

  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clock_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output (two clk edges of latency)
module clock_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage 0: capture, may go metastable
      meta_p0 <= d;
      // stage 1: resolved copy
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/clock_route_path_ctrl.sv
// Glitch-safe reconfiguration sequencer for a routed clock path.
// A request drops the route enable, waits GAP_CYCLES, switches the sync mux
// select, waits SETTLE_CYCLES, and (if the request asks for enable) re-enables
// the route and confirms that the routed clock is toggling via route_fb.
// All outputs are registered and follow the sequencer state by one edge.
// Ports:
//   clk, rst                - block clock, asynchronous active-high reset
//   req_valid/req_ready     - request handshake (ready only in IDLE)
//   req_sel, req_en         - target select and target enable
//   done_valid, done_err    - one-cycle completion pulse, err = feedback timeout
//   control_path_enable     - registered route output mux enable
//   clock_route_path_syncer - registered sync mux select
//   route_fb                - routed clock returned asynchronously
//   route_active            - feedback toggle confirmed since last accept
module clock_route_path_ctrl
  import clock_route_pkg::*;
#(
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  input  logic req_en,
  output logic req_ready,
  output logic done_valid,
  output logic done_err,
  output logic control_path_enable,
  output logic clock_route_path_syncer,
  input  logic route_fb,
  output logic route_active
);

  localparam int CNT_MAX = max3(GAP_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);

  route_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic en_cap, en_cap_nxt;
  logic sel_cap;
  logic res_ok, res_ok_nxt;
  logic res_err, res_err_nxt;

  logic enable_nxt, syncer_nxt, active_nxt;
  logic done_valid_nxt, done_err_nxt;

  logic fb_sync_p1;
  logic fb_dly_p2;
  logic fb_edge;

  // feedback stages 0-1: resynchronize the routed clock
  clock_sync_2ff u_fb_sync (
    .clk (clk),
    .rst (rst),
    .d   (route_fb),
    .q   (fb_sync_p1)
  );

  // feedback stage 2: one-cycle delay for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fb_dly_p2 <= 1'b0;
    else     fb_dly_p2 <= fb_sync_p1;
  end

  assign fb_edge   = fb_sync_p1 ^ fb_dly_p2;
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    en_cap_nxt     = en_cap;
    res_ok_nxt     = res_ok;
    res_err_nxt    = res_err;
    enable_nxt     = control_path_enable;
    syncer_nxt     = clock_route_path_syncer;
    active_nxt     = route_active;
    done_valid_nxt = 1'b0;
    done_err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt   = DRAIN;
          en_cap_nxt  = req_en;
          res_ok_nxt  = 1'b0;
          res_err_nxt = 1'b0;
        end
      end
      DRAIN: begin
        enable_nxt = 1'b0;
        active_nxt = 1'b0;
        if (cnt == GAP_LAST) state_nxt = SWITCH;
      end
      SWITCH: begin
        enable_nxt = 1'b0;
        active_nxt = 1'b0;
        syncer_nxt = sel_cap;
        state_nxt  = SETTLE;
      end
      SETTLE: begin
        enable_nxt = 1'b0;
        active_nxt = 1'b0;
        if (cnt == SETTLE_LAST) state_nxt = en_cap ? CHECK : DONE;
      end
      CHECK: begin
        enable_nxt = 1'b1;
        // an edge in the last timeout cycle wins over the timeout
        if (fb_edge) begin
          res_ok_nxt = 1'b1;
          state_nxt  = DONE;
        end else if (cnt == TO_LAST) begin
          res_err_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        // a timeout pulls the enable back down together with the error pulse
        enable_nxt     = en_cap & ~res_err;
        active_nxt     = res_ok;
        done_valid_nxt = 1'b1;
        done_err_nxt   = res_err;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // cleared on every state change, saturates instead of wrapping
    if (state_nxt != state)  cnt_nxt = '0;
    else if (cnt == CNT_SAT) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_cap                  <= 1'b0;
      res_ok                  <= 1'b0;
      res_err                 <= 1'b0;
      control_path_enable     <= 1'b0;
      clock_route_path_syncer <= 1'b0;
      route_active            <= 1'b0;
      done_valid              <= 1'b0;
      done_err                <= 1'b0;
    end else begin
      en_cap                  <= en_cap_nxt;
      res_ok                  <= res_ok_nxt;
      res_err                 <= res_err_nxt;
      control_path_enable     <= enable_nxt;
      clock_route_path_syncer <= syncer_nxt;
      route_active            <= active_nxt;
      done_valid              <= done_valid_nxt;
      done_err                <= done_err_nxt;
    end
  end

  // captured select is pure data and only read after an accept
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) sel_cap <= req_sel;
  end

endmodule

// File: tb/tb_clock_route_path_ctrl.sv
module tb_clock_route_path_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic req_en = 1'b0;
  logic route_fb = 1'b0;
  logic req_ready, done_valid, done_err;
  logic control_path_enable, clock_route_path_syncer, route_active;

  clock_route_path_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .req_valid               (req_valid),
    .req_sel                 (req_sel),
    .req_en                  (req_en),
    .req_ready               (req_ready),
    .done_valid              (done_valid),
    .done_err                (done_err),
    .control_path_enable     (control_path_enable),
    .clock_route_path_syncer (clock_route_path_syncer),
    .route_fb                (route_fb),
    .route_active            (route_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic  err;
    logic  active;
    logic  enable;
    int    lo;
    int    hi;
    string name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_edge = 0;
  logic fb_run = 1'b0;
  int   fb_kick = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done_valid=1 with nothing outstanding (edge %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_err"}, int'(done_err), int'(mon_e.err));
        check({mon_e.name, "_active"}, int'(route_active), int'(mon_e.active));
        check({mon_e.name, "_enable"}, int'(control_path_enable), int'(mon_e.enable));
        n_chk++;
        if (cyc < mon_e.lo || cyc > mon_e.hi) begin
          n_fail++;
          $display("FAIL %s_latency: done at edge %0d required %0d..%0d",
                   mon_e.name, cyc, mon_e.lo, mon_e.hi);
        end
      end
    end else begin
      check("done_err_idle", int'(done_err), 0);
    end
  end

  // routed clock feedback model: toggle every 3 clk when running, or once per kick
  initial begin
    int seen;
    int ph;
    seen = 0;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      if (fb_kick != seen) begin
        seen = fb_kick;
        route_fb = ~route_fb;
      end else if (fb_run) begin
        ph++;
        if (ph >= 3) begin
          ph = 0;
          route_fb = ~route_fb;
        end
      end
    end
  end

  task automatic issue(input logic sel, input logic en);
    @(negedge clk);
    req_sel = sel;
    req_en = en;
    req_valid = 1'b1;
    acc_edge = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic to_edge(input int k);
    while (cyc < acc_edge + k) @(negedge clk);
  endtask

  task automatic push(input logic err, input logic active, input logic enable,
                      input int lo, input int hi, input string name);
    exp_t e;
    e.err = err;
    e.active = active;
    e.enable = enable;
    e.lo = acc_edge + lo;
    e.hi = acc_edge + hi;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({nm, "_drained"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 1);
    check("rst_enable", int'(control_path_enable), 0);
    check("rst_syncer", int'(clock_route_path_syncer), 0);
    check("rst_done_valid", int'(done_valid), 0);
    check("rst_active", int'(route_active), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(req_ready), 1);

    // sel=1 en=1 with toggling feedback
    fb_run = 1'b1;
    issue(1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 11, 16, "fb_ok");
    to_edge(1);
    check("a_enable_e1", int'(control_path_enable), 0);
    check("a_ready_e1", int'(req_ready), 0);
    to_edge(4);
    check("a_syncer_e4", int'(clock_route_path_syncer), 0);
    to_edge(5);
    check("a_syncer_e5", int'(clock_route_path_syncer), 1);
    to_edge(9);
    check("a_enable_e9", int'(control_path_enable), 0);
    to_edge(10);
    check("a_enable_e10", int'(control_path_enable), 1);
    wait_drain(40, "a");
    fb_run = 1'b0;
    repeat (6) @(negedge clk);
    check("a_active_after", int'(route_active), 1);

    // en=0 sel=0
    issue(1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 10, 10, "en0");
    to_edge(1);
    check("b_active_e1", int'(route_active), 0);
    check("b_enable_e1", int'(control_path_enable), 0);
    to_edge(4);
    check("b_syncer_e4", int'(clock_route_path_syncer), 1);
    to_edge(5);
    check("b_syncer_e5", int'(clock_route_path_syncer), 0);
    to_edge(10);
    check("b_enable_e10", int'(control_path_enable), 0);
    wait_drain(40, "b");

    // en=1 with quiet feedback -> timeout
    issue(1'b1, 1'b1);
    push(1'b1, 1'b0, 1'b0, 74, 74, "timeout");
    to_edge(73);
    check("c_enable_e73", int'(control_path_enable), 1);
    to_edge(74);
    check("c_enable_e74", int'(control_path_enable), 0);
    wait_drain(20, "c");
    check("c_active_after", int'(route_active), 0);

    // req_valid held high across two sequences
    @(negedge clk);
    req_sel = 1'b1;
    req_en = 1'b0;
    req_valid = 1'b1;
    acc_edge = cyc + 1;
    push(1'b0, 1'b0, 1'b0, 10, 10, "held1");
    push(1'b0, 1'b0, 1'b0, 21, 21, "held2");
    to_edge(1);
    check("d_ready_e1", int'(req_ready), 0);
    to_edge(9);
    check("d_ready_e9", int'(req_ready), 0);
    to_edge(10);
    check("d_ready_e10", int'(req_ready), 1);
    to_edge(11);
    check("d_ready_e11", int'(req_ready), 0);
    req_valid = 1'b0;
    wait_drain(40, "d");

    // reset pulsed in SETTLE aborts silently
    issue(1'b1, 1'b1);
    to_edge(7);
    #2 rst = 1'b1;
    #1;
    check("e_rst_syncer", int'(clock_route_path_syncer), 0);
    check("e_rst_enable", int'(control_path_enable), 0);
    check("e_rst_ready", int'(req_ready), 1);
    check("e_rst_done_valid", int'(done_valid), 0);
    check("e_rst_active", int'(route_active), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    fb_run = 1'b1;
    issue(1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 11, 16, "after_rst");
    wait_drain(40, "e");
    fb_run = 1'b0;
    repeat (6) @(negedge clk);

    // feedback edge only during DRAIN -> ignored, timeout
    issue(1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 74, 74, "drain_edge");
    to_edge(1);
    fb_kick++;
    wait_drain(120, "f");
    check("f_enable_after", int'(control_path_enable), 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
